// File: rtl/sp_ram_adapter_pkg.sv
// Shared helpers for the SRAM request adapter: byte-lane and address-offset arithmetic.
// Used by sp_ram_req_adapter; alignment checking there is gated by SP_RAM_ADAPTER_ALIGN_CHECK_EN.
package sp_ram_adapter_pkg;

   // Tag half of a response; the data half is sized by the instantiating module.
   typedef struct packed {
      logic we;
      logic err;
   } resp_tag_t;

   function automatic int unsigned lane_count(input int unsigned dw);
      return dw / 8;
   endfunction

   function automatic int unsigned off_width(input int unsigned dw);
      return $clog2(dw / 8);
   endfunction

   function automatic logic [63:0] word_addr(input logic [63:0] byte_addr, input int unsigned dw);
      return byte_addr >> off_width(dw);
   endfunction

   function automatic logic misaligned(input logic [63:0] byte_addr, input int unsigned dw);
      return (byte_addr & ((64'd1 << off_width(dw)) - 64'd1)) != 64'd0;
   endfunction

endpackage

// File: rtl/sp_ram_resp_fifo.sv
// Synchronous response FIFO for sp_ram_req_adapter: DEPTH entries (power of 2), sync active-high reset.
// Caller never pushes when full nor pops when empty.
module sp_ram_resp_fifo #(
   parameter int DEPTH = 2,
   parameter int WIDTH = 34,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty,
   output logic [CNT_W-1:0] cnt
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] wr_ptr;

   // NOTE: storage is deliberately not reset; the pointers and count alone decide which entries are valid.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= din;
      end
   end

   // NOTE: all state updates use non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({push, pop})
            2'b10:   cnt <= cnt + CNT_W'(1);
            2'b01:   cnt <= cnt - CNT_W'(1);
            default: cnt <= cnt;
         endcase
      end
   end

   assign dout  = mem[rd_ptr];
   assign full  = (cnt == CNT_W'(DEPTH));
   assign empty = (cnt == '0);

endmodule

// File: rtl/sp_ram_req_adapter.sv
// Req/gnt + rvalid/rready front-end for the byte-enabled single-port SRAM, with in-order buffered responses.
// Define SP_RAM_ADAPTER_ALIGN_CHECK_EN to reject misaligned byte addresses with an error response.
module sp_ram_req_adapter
   import sp_ram_adapter_pkg::*;
#(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 32,
   parameter int BUF_DEPTH  = 2,
   localparam int NB   = DATA_WIDTH / 8,
   localparam int BA_W = ADDR_WIDTH + $clog2(NB)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_i,
   output logic                  gnt_o,
   input  logic [BA_W-1:0]       addr_i,
   input  logic                  we_i,
   input  logic [NB-1:0]         be_i,
   input  logic [DATA_WIDTH-1:0] wdata_i,
   output logic                  rvalid_o,
   input  logic                  rready_i,
   output logic [DATA_WIDTH-1:0] rdata_o,
   output logic                  rwe_o,
   output logic                  err_o,
   output logic                  ram_en_o,
   output logic                  ram_we_o,
   output logic [ADDR_WIDTH-1:0] ram_addr_o,
   output logic [NB-1:0]         ram_be_o,
   output logic [DATA_WIDTH-1:0] ram_wdata_o,
   input  logic [DATA_WIDTH-1:0] ram_rdata_i
);

   typedef struct packed {
      logic [DATA_WIDTH-1:0] rdata;
      resp_tag_t             tag;
   } resp_t;

   localparam int CNT_W = $clog2(BUF_DEPTH + 1);

   logic             infl;
   logic             infl_we;
   logic             infl_err;
   logic             accept;
   logic             mis;
   resp_t            resp_now;
   resp_t            fifo_head;
   logic             fifo_push;
   logic             fifo_pop;
   logic             fifo_full;
   logic             fifo_empty;
   logic [CNT_W-1:0] fifo_cnt;

   // cnt + infl < BUF_DEPTH, written so the grant depends only on registered state.
   assign gnt_o  = !rst && !fifo_full && !(infl && (fifo_cnt == CNT_W'(BUF_DEPTH - 1)));
   assign accept = req_i && gnt_o;

`ifdef SP_RAM_ADAPTER_ALIGN_CHECK_EN
   assign mis = misaligned(64'(addr_i), DATA_WIDTH);
`else
   assign mis = 1'b0;
`endif

   assign ram_en_o    = accept && !mis;
   assign ram_we_o    = ram_en_o && we_i;
   assign ram_be_o    = ram_en_o ? be_i : '0;
   assign ram_addr_o  = ADDR_WIDTH'(word_addr(64'(addr_i), DATA_WIDTH));
   assign ram_wdata_o = wdata_i;

   always_ff @(posedge clk) begin
      if (rst) begin
         infl     <= 1'b0;
         infl_we  <= 1'b0;
         infl_err <= 1'b0;
      end else begin
         infl     <= accept;
         infl_we  <= we_i;
         infl_err <= mis;
      end
   end

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      resp_now         = '0;
      resp_now.tag.we  = infl_we;
      resp_now.tag.err = infl_err;
      if (!infl_we && !infl_err) begin
         resp_now.rdata = ram_rdata_i;
      end
   end

   // A fresh response skips the buffer only when nothing older is waiting and it is taken at once.
   assign fifo_pop  = !rst && !fifo_empty && rready_i;
   assign fifo_push = !rst && infl && !(fifo_empty && rready_i);

   sp_ram_resp_fifo #(
      .DEPTH (BUF_DEPTH),
      .WIDTH ($bits(resp_t))
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (fifo_push),
      .din   (resp_now),
      .pop   (fifo_pop),
      .dout  (fifo_head),
      .full  (fifo_full),
      .empty (fifo_empty),
      .cnt   (fifo_cnt)
   );

   always_comb begin
      rvalid_o = 1'b0;
      rdata_o  = '0;
      rwe_o    = 1'b0;
      err_o    = 1'b0;
      if (!rst) begin
         if (!fifo_empty) begin
            rvalid_o = 1'b1;
            rdata_o  = fifo_head.rdata;
            rwe_o    = fifo_head.tag.we;
            err_o    = fifo_head.tag.err;
         end else if (infl) begin
            rvalid_o = 1'b1;
            rdata_o  = resp_now.rdata;
            rwe_o    = resp_now.tag.we;
            err_o    = resp_now.tag.err;
         end
      end
   end

endmodule

// File: tb/tb_sp_ram_req_adapter.sv
// Scoreboard bench for sp_ram_req_adapter: directed requests push expected responses, a monitor pops and compares.
// Honours SP_RAM_ADAPTER_ALIGN_CHECK_EN for the misaligned-read case.
module tb_sp_ram_req_adapter;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_i;
   logic        gnt_o;
   logic [9:0]  addr_i;
   logic        we_i;
   logic [3:0]  be_i;
   logic [31:0] wdata_i;
   logic        rvalid_o;
   logic        rready_i;
   logic [31:0] rdata_o;
   logic        rwe_o;
   logic        err_o;
   logic        ram_en_o;
   logic        ram_we_o;
   logic [7:0]  ram_addr_o;
   logic [3:0]  ram_be_o;
   logic [31:0] ram_wdata_o;
   logic [31:0] ram_rdata_i = '0;

   always #5 clk = ~clk;

   sp_ram_req_adapter dut (
      .clk         (clk),
      .rst         (rst),
      .req_i       (req_i),
      .gnt_o       (gnt_o),
      .addr_i      (addr_i),
      .we_i        (we_i),
      .be_i        (be_i),
      .wdata_i     (wdata_i),
      .rvalid_o    (rvalid_o),
      .rready_i    (rready_i),
      .rdata_o     (rdata_o),
      .rwe_o       (rwe_o),
      .err_o       (err_o),
      .ram_en_o    (ram_en_o),
      .ram_we_o    (ram_we_o),
      .ram_addr_o  (ram_addr_o),
      .ram_be_o    (ram_be_o),
      .ram_wdata_o (ram_wdata_o),
      .ram_rdata_i (ram_rdata_i)
   );

   // Behavioural SRAM behind the adapter: one-cycle read latency, byte-lane writes.
   logic [31:0] mem [256];
   initial for (int i = 0; i < 256; i++) mem[i] = '0;

   always @(posedge clk) begin
      if (ram_en_o) begin
         if (ram_we_o) begin
            for (int b = 0; b < 4; b++)
               if (ram_be_o[b]) mem[ram_addr_o][8*b +: 8] <= ram_wdata_o[8*b +: 8];
         end else begin
            ram_rdata_i <= mem[ram_addr_o];
         end
      end
   end

   typedef struct {
      logic [31:0] rdata;
      logic        we;
      logic        err;
   } exp_t;

   exp_t q[$];
   int   n_cmp = 0;
   int   n_bad = 0;
   logic rand_rr = 1'b0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: compares every consumed response against the queue head and checks stall stability.
   initial begin
      logic        held = 1'b0;
      logic [33:0] held_v = '0;
      exp_t        e;
      forever begin
         @(negedge clk);
         if (rst) begin
            held = 1'b0;
         end else begin
            if (held) begin
               check("rvalid_hold", 64'(rvalid_o), 64'd1);
               check("stall_stable", 64'({rdata_o, rwe_o, err_o}), 64'(held_v));
            end
            if (rvalid_o && rready_i) begin
               if (q.size() == 0) begin
                  n_cmp++;
                  n_bad++;
                  $display("FAIL unexpected_resp: got rdata 0x%0h with no expected entry at %0t", rdata_o, $time);
               end else begin
                  e = q.pop_front();
                  check("resp_rdata", 64'(rdata_o), 64'(e.rdata));
                  check("resp_rwe", 64'(rwe_o), 64'(e.we));
                  check("resp_err", 64'(err_o), 64'(e.err));
               end
               held = 1'b0;
            end else if (rvalid_o) begin
               held   = 1'b1;
               held_v = {rdata_o, rwe_o, err_o};
            end else begin
               held = 1'b0;
            end
         end
      end
   end

   // Random response back-pressure for the mixed traffic phase.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (rand_rr) rready_i = 1'($urandom_range(0, 1));
      end
   end

   task automatic issue(input logic [9:0] a, input logic w, input logic [3:0] b, input logic [31:0] d,
                        input logic [31:0] exp_rd, input logic exp_err,
                        output logic en_seen, output logic rv_seen, output int waits);
      waits   = 0;
      req_i   = 1'b1;
      addr_i  = a;
      we_i    = w;
      be_i    = b;
      wdata_i = d;
      @(negedge clk);
      while (!gnt_o && waits < 50) begin
         waits++;
         @(negedge clk);
      end
      if (!gnt_o) begin
         n_cmp++;
         n_bad++;
         $display("FAIL grant_timeout: no gnt_o for addr 0x%0h after %0d cycles", a, waits);
      end else begin
         q.push_back('{rdata: exp_rd, we: w, err: exp_err});
      end
      en_seen = ram_en_o;
      rv_seen = rvalid_o;
      @(posedge clk);
      #1;
      req_i = 1'b0;
      we_i  = 1'b0;
      be_i  = '0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic en, rv;
      int   w8, grants, guard;

      rst      = 1'b1;
      req_i    = 1'b1;
      addr_i   = 10'h010;
      we_i     = 1'b1;
      be_i     = 4'hF;
      wdata_i  = 32'hDEAD_BEEF;
      rready_i = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_gnt", 64'(gnt_o), 64'd0);
      check("rst_rvalid", 64'(rvalid_o), 64'd0);
      check("rst_ram_en", 64'(ram_en_o), 64'd0);
      check("rst_ram_we", 64'(ram_we_o), 64'd0);
      check("rst_ram_be", 64'(ram_be_o), 64'd0);
      check("rst_outs", 64'({rdata_o, rwe_o, err_o}), 64'd0);
      @(posedge clk);
      #1;
      rst   = 1'b0;
      req_i = 1'b0;
      we_i  = 1'b0;
      be_i  = '0;
      @(negedge clk);
      check("first_gnt_after_rst", 64'(gnt_o), 64'd1);
      @(posedge clk);
      #1;

      // Partial-lane write then read-back of word 4.
      issue(10'h010, 1'b1, 4'b0101, 32'hAABB_CCDD, 32'h0, 1'b0, en, rv, w8);
      check("wr_ram_en", 64'(en), 64'd1);
      issue(10'h010, 1'b0, 4'b0000, 32'h0, 32'h00BB_00DD, 1'b0, en, rv, w8);
      check("rd_ram_en", 64'(en), 64'd1);

      // Fill words 8..15, then eight back-to-back reads.
      for (int i = 0; i < 8; i++)
         issue(10'((8 + i) * 4), 1'b1, 4'hF, 32'h1111_1111 * (i + 1), 32'h0, 1'b0, en, rv, w8);
      for (int i = 0; i < 8; i++) begin
         issue(10'((8 + i) * 4), 1'b0, 4'h0, 32'h0, 32'h1111_1111 * (i + 1), 1'b0, en, rv, w8);
         check("b2b_gnt_wait", 64'(w8), 64'd0);
         if (i > 0) check("b2b_rvalid_n1", 64'(rv), 64'd1);
      end
      repeat (2) @(posedge clk);
      #1;

      // Stalled responses: only BUF_DEPTH grants, then release.
      rready_i = 1'b0;
      req_i    = 1'b1;
      addr_i   = 10'h020;
      we_i     = 1'b0;
      be_i     = '0;
      grants   = 0;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         if (gnt_o) begin
            grants++;
            q.push_back('{rdata: 32'h1111_1111, we: 1'b0, err: 1'b0});
         end
         @(posedge clk);
         #1;
      end
      req_i = 1'b0;
      check("stall_grants", 64'(grants), 64'd2);
      rready_i = 1'b1;
      @(negedge clk);
      check("gnt_still_full", 64'(gnt_o), 64'd0);
      @(posedge clk);
      #1;
      @(negedge clk);
      check("gnt_resumes", 64'(gnt_o), 64'd1);
      repeat (2) @(posedge clk);
      #1;

      // Reset with a buffered and an in-flight response outstanding.
      rready_i = 1'b0;
      req_i    = 1'b1;
      addr_i   = 10'h024;
      grants   = 0;
      guard    = 0;
      while (grants < 2 && guard < 10) begin
         guard++;
         @(negedge clk);
         if (gnt_o) grants++;
         @(posedge clk);
         #1;
      end
      check("pre_rst_grants", 64'(grants), 64'd2);
      rst = 1'b1;
      q.delete();
      @(negedge clk);
      check("midrst_rvalid", 64'(rvalid_o), 64'd0);
      check("midrst_gnt", 64'(gnt_o), 64'd0);
      check("midrst_ram_en", 64'(ram_en_o), 64'd0);
      @(posedge clk);
      #1;
      rst      = 1'b0;
      req_i    = 1'b0;
      rready_i = 1'b1;
      @(negedge clk);
      check("post_rst_flushed", 64'(rvalid_o), 64'd0);
      @(posedge clk);
      #1;
      issue(10'h024, 1'b0, 4'h0, 32'h0, 32'h2222_2222, 1'b0, en, rv, w8);

      // Misaligned read of byte 0x13.
`ifdef SP_RAM_ADAPTER_ALIGN_CHECK_EN
      issue(10'h013, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, en, rv, w8);
      check("misaligned_ram_en", 64'(en), 64'd0);
`else
      issue(10'h013, 1'b0, 4'h0, 32'h0, 32'h00BB_00DD, 1'b0, en, rv, w8);
      check("misaligned_ram_en", 64'(en), 64'd1);
`endif

      // Alternating write/read of word 20 under random back-pressure.
      rand_rr = 1'b1;
      for (int k = 0; k < 6; k++) begin
         issue(10'h050, 1'b1, 4'hF, 32'h5A5A_0000 + k, 32'h0, 1'b0, en, rv, w8);
         issue(10'h050, 1'b0, 4'h0, 32'h0, 32'h5A5A_0000 + k, 1'b0, en, rv, w8);
      end
      rand_rr = 1'b0;
      @(posedge clk);
      #2;
      rready_i = 1'b1;
      guard    = 0;
      while (q.size() != 0 && guard < 50) begin
         guard++;
         @(negedge clk);
      end
      check("drain_empty", 64'(q.size()), 64'd0);

      repeat (2) @(posedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
